// File: rtl/banco_registradores_pkg.sv
// banco_registradores_pkg: shared defaults and clear-sweep FSM states
package banco_registradores_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} clr_state_e;
endpackage

// File: rtl/banco_registradores_if.sv
// banco_registradores_if: register-bank access bus (read/write/clear ports)
interface banco_registradores_if #(
  parameter int DATA_WIDTH = banco_registradores_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = banco_registradores_pkg::ADDR_WIDTH_DEF
);
  logic [ADDR_WIDTH-1:0] Read1;
  logic [ADDR_WIDTH-1:0] Read2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  Clear;
  logic [DATA_WIDTH-1:0] Data1;
  logic [DATA_WIDTH-1:0] Data2;
  logic                  Busy;
  logic                  Done;
  modport master (output Read1, Read2, WriteReg, WriteData, RegWrite, Clear,
                  input Data1, Data2, Busy, Done);
  modport slave (input Read1, Read2, WriteReg, WriteData, RegWrite, Clear,
                 output Data1, Data2, Busy, Done);
endinterface

// File: rtl/banco_clear_seq.sv
// banco_clear_seq: IDLE/SWEEP/DONE sequencer zeroing one register per cycle
module banco_clear_seq
  import banco_registradores_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  clr_en_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(2**ADDR_WIDTH - 1);
  clr_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
  // Register 0 is hardwired, so the sweep starts at 1 and ends at LAST.
  always_comb begin
    state_d    = state_q == IDLE  ? (start_i ? SWEEP : IDLE) :
                 state_q == SWEEP ? (ptr_q == LAST ? DONE : SWEEP) : IDLE;
    ptr_d      = state_q == IDLE  ? (start_i ? ADDR_WIDTH'(1) : '0) :
                 state_q == SWEEP ? ptr_q + 1'b1 : '0;
    busy_o     = state_q == SWEEP;
    done_o     = state_q == DONE;
    clr_en_o   = state_q == SWEEP;
    clr_addr_o = ptr_q;
  end
endmodule

// File: rtl/banco_registradores.sv
// banco_registradores: 2R1W register bank, r0 hardwired to 0, sweep clear
// Define BANCO_REGISTRADORES_BYPASS_EN to forward accepted writes to same-cycle reads.
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic clock,
  input logic reset,
  banco_registradores_if.slave bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic busy, done, clr_en, we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  banco_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
    .clk(clock),
    .rst(reset),
    .start_i(bus.Clear),
    .busy_o(busy),
    .done_o(done),
    .clr_en_o(clr_en),
    .clr_addr_o(clr_addr)
  );
  assign we = bus.RegWrite && !busy && bus.WriteReg != '0;
  always_ff @(posedge clock) begin
    if (reset) regs_q <= '{default: '0};
    else begin
      if (clr_en) regs_q[clr_addr] <= '0;
      if (we) regs_q[bus.WriteReg] <= bus.WriteData;
    end
  end
`ifdef BANCO_REGISTRADORES_BYPASS_EN
  assign bus.Data1 = (we && bus.Read1 == bus.WriteReg) ? bus.WriteData : regs_q[bus.Read1];
  assign bus.Data2 = (we && bus.Read2 == bus.WriteReg) ? bus.WriteData : regs_q[bus.Read2];
`else
  assign bus.Data1 = regs_q[bus.Read1];
  assign bus.Data2 = regs_q[bus.Read2];
`endif
  assign bus.Busy = busy;
  assign bus.Done = done;
endmodule

// File: tb/tb_banco_registradores.sv
// tb_banco_registradores: directed + random checks against a behavioural bank model
module tb_banco_registradores;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  logic clock = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] mdl [NR];
  int left = 0;
  logic done_m = 1'b0;
  banco_registradores_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  banco_registradores #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    if (bus.RegWrite && left == 0 && bus.WriteReg != '0 && a == bus.WriteReg) return bus.WriteData;
`endif
    return mdl[a];
  endfunction

  task automatic drive(input logic rst, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [AW-1:0] wr, input logic [DW-1:0] wd, input logic we,
                       input logic clr);
    @(negedge clock);
    reset = rst;
    bus.Read1 = r1;
    bus.Read2 = r2;
    bus.WriteReg = wr;
    bus.WriteData = wd;
    bus.RegWrite = we;
    bus.Clear = clr;
    #1;
  endtask

  task automatic upd();
    if (reset) begin
      foreach (mdl[i]) mdl[i] = '0;
      left = 0;
      done_m = 1'b0;
    end else if (left > 0) begin
      mdl[NR - left] = '0;
      left--;
      done_m = (left == 0);
    end else begin
      if (bus.RegWrite && bus.WriteReg != '0) mdl[bus.WriteReg] = bus.WriteData;
      if (!done_m && bus.Clear) left = NR - 1;
      done_m = 1'b0;
    end
  endtask

  task automatic tick();
    chk("data1", bus.Data1, exp_rd(bus.Read1));
    chk("data2", bus.Data2, exp_rd(bus.Read2));
    chk("busy", DW'(bus.Busy), DW'(left > 0));
    chk("done", DW'(bus.Done), DW'(done_m));
    @(posedge clock);
    upd();
  endtask

  task automatic fill();
    for (int i = 1; i < NR; i++) begin
      drive(1'b0, AW'(i), '0, AW'(i), DW'(i), 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic full_sweep(input string tag);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < NR - 1; c++) begin
      drive(1'b0, AW'($urandom), AW'(5), AW'(5), 32'h7, 1'b1, c % 7 == 0);
      chk({tag, "_busy"}, DW'(bus.Busy), 32'd1);
      tick();
    end
    drive(1'b0, AW'(5), '0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_done"}, DW'(bus.Done), 32'd1);
    chk({tag, "_done_busy"}, DW'(bus.Busy), 32'd0);
    tick();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    chk({tag, "_done_once"}, DW'(bus.Done), 32'd0);
    chk({tag, "_no_requeue"}, DW'(bus.Busy), 32'd0);
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, AW'(i), AW'(NR - 1 - i), '0, '0, 1'b0, 1'b0);
      chk({tag, "_zero"}, bus.Data1, 32'h0);
      tick();
    end
  endtask

  initial begin
    drive(1'b1, '0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clock);
    upd();
    drive(1'b1, '0, '0, '0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("rst_busy", DW'(bus.Busy), 32'd0);
    chk("rst_done", DW'(bus.Done), 32'd0);
    tick();
    drive(1'b0, '0, '0, AW'(9), 32'h6, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, AW'(1), 32'h4, 1'b1, 1'b0);
    tick();
    drive(1'b0, AW'(9), AW'(1), '0, '0, 1'b0, 1'b0);
    chk("r9", bus.Data1, 32'h6);
    chk("r1", bus.Data2, 32'h4);
    tick();
    drive(1'b0, '0, '0, '0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    chk("r0", bus.Data1, 32'h0);
    tick();
    drive(1'b0, AW'(7), '0, AW'(7), 32'h3, 1'b1, 1'b0);
    tick();
    drive(1'b0, AW'(7), AW'(7), AW'(7), 32'h8, 1'b1, 1'b0);
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    chk("wr_same", bus.Data1, 32'h8);
`else
    chk("wr_same", bus.Data1, 32'h3);
`endif
    tick();
    drive(1'b0, AW'(7), '0, '0, '0, 1'b0, 1'b0);
    chk("wr_next", bus.Data1, 32'h8);
    tick();
    fill();
    drive(1'b0, AW'(20), AW'(31), '0, '0, 1'b0, 1'b0);
    chk("fill20", bus.Data1, 32'd20);
    chk("fill31", bus.Data2, 32'd31);
    tick();
    full_sweep("sweep");
    fill();
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, AW'(c + 1), AW'(c + 12), '0, '0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, '0, '0, '0, '0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < NR; i++) begin
      drive(1'b0, AW'(i), AW'(i), '0, '0, 1'b0, 1'b0);
      chk("abort_zero", bus.Data1, 32'h0);
      chk("abort_busy", DW'(bus.Busy), 32'd0);
      chk("abort_done", DW'(bus.Done), 32'd0);
      tick();
    end
    fill();
    full_sweep("resweep");
    drive(1'b0, '0, '0, AW'(3), 32'hA5A5_0003, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < NR; c++) begin
      drive(1'b0, AW'(3), '0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, AW'($urandom), AW'($urandom), AW'($urandom),
            $urandom, 1'($urandom), $urandom_range(0, 39) == 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
